// File: rtl/nms_stream_pkg.sv
// Shared definitions for the non-maximum suppression stage.
//   - Direction codes for the 2-bit quantised gradient angle.
//   - Frame-level state encoding used by the stream controller.
package nms_stream_pkg;

  localparam logic [1:0] ANG_H    = 2'd0;  // horizontal gradient: compare W / E
  localparam logic [1:0] ANG_D45  = 2'd1;  // NE-SW diagonal
  localparam logic [1:0] ANG_V    = 2'd2;  // vertical gradient: compare N / S
  localparam logic [1:0] ANG_D135 = 2'd3;  // NW-SE diagonal

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/nms_stream_if.sv
// Pixel stream bundle between the Sobel stage, the NMS stage and the
// hysteresis stage.
//   slave  : the NMS block (consumes in_*, drives in_ready and out_*)
//   master : the upstream/downstream environment
interface nms_stream_if #(
  parameter int MAG_W = 11
) ();
  logic             in_valid;
  logic             in_ready;
  logic             in_sof;
  logic [MAG_W-1:0] in_mag;
  logic [1:0]       in_angle;
  logic             out_valid;
  logic             out_sof;
  logic             out_eof;
  logic [MAG_W-1:0] out_mag;

  modport slave (
    input  in_valid, in_sof, in_mag, in_angle,
    output in_ready, out_valid, out_sof, out_eof, out_mag
  );

  modport master (
    output in_valid, in_sof, in_mag, in_angle,
    input  in_ready, out_valid, out_sof, out_eof, out_mag
  );
endinterface

// File: rtl/nms_line_buffer.sv
// Circular delay line of IMG_W entries. Each enabled cycle writes din into
// the slot under the pointer; dout shows that slot's previous content, i.e.
// the value written IMG_W enables ago.
//   clk, rst : clock, async active-high reset (pointer only)
//   en       : advance the delay line
//   din/dout : DATA_W-wide pixel in / pixel delayed by one line
module nms_line_buffer #(
  parameter int IMG_W  = 640,
  parameter int DATA_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  localparam int PTR_W = $clog2(IMG_W);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(IMG_W - 1);

  logic [DATA_W-1:0] mem [IMG_W];
  logic [PTR_W-1:0]  ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en) ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  // Storage carries no reset; contents are never observed before rewrite.
  always_ff @(posedge clk) begin
    if (en) mem[ptr_q] <= din;
  end

  assign dout = mem[ptr_q];
endmodule

// File: rtl/nms_stream.sv
// Streaming non-maximum suppression.
// Takes raster-order {angle, magnitude} pixels, keeps a magnitude only where it
// is a local maximum along its gradient direction, zeroes everything else and
// all border pixels. Output pixel q = p-(IMG_W+1) leaves one cycle after input
// pixel p; the last IMG_W+1 outputs are flushed autonomously with in_ready low.
//   clk, rst : clock, async active-high reset
//   s        : stream bundle (slave side), see nms_stream_if
module nms_stream
  import nms_stream_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int MAG_W = 11
) (
  input  logic         clk,
  input  logic         rst,
  nms_stream_if.slave  s
);
  localparam int PIX_W = MAG_W + 2;
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int FL_W  = $clog2(IMG_W + 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);

  function automatic logic keep_fn(input logic [MAG_W-1:0] c,
                                   input logic [MAG_W-1:0] early,
                                   input logic [MAG_W-1:0] late);
    // Strict against the raster-earlier neighbour, non-strict against the
    // later one, so a plateau keeps exactly its first pixel.
    return (c > early) && (c >= late);
  endfunction

  state_t           state_q, state_d;
  logic [COL_W-1:0] pcol_q, pcol_d, qcol_q, qcol_d, cur_col;
  logic [ROW_W-1:0] prow_q, prow_d, qrow_q, qrow_d, cur_row;
  logic [FL_W-1:0]  flush_q, flush_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d, out_sof_q, out_sof_d;
  logic             out_eof_q, out_eof_d;
  logic [MAG_W-1:0] out_mag_q, out_mag_d;

  logic xfer, start, take, flushing, shift, emit, interior;

  logic [PIX_W-1:0] pix_in, lb0_dout, lb1_dout;
  logic [PIX_W-1:0] w_q [3][2];
  logic [PIX_W-1:0] w_d [3][2];
  logic [MAG_W-1:0] c_mag, early, late;
  logic [1:0]       c_ang;

  assign xfer     = s.in_valid && in_ready_q;
  assign start    = xfer && s.in_sof;
  assign take     = start || (xfer && state_q == RUN);
  assign flushing = (state_q == FLUSH);
  assign shift    = take || flushing;
  assign cur_col  = start ? '0 : pcol_q;
  assign cur_row  = start ? '0 : prow_q;
  assign emit     = flushing ||
                    (take && (cur_row >= ROW_W'(2) ||
                              (cur_row == ROW_W'(1) && cur_col != '0)));

  // Flush cycles feed zeros; their outputs are all border pixels anyway.
  assign pix_in = flushing ? '0 : {s.in_angle, s.in_mag};

  // Stage 0: line delays. Row 1 of the new column is p-IMG_W, row 0 is p-2*IMG_W.
  nms_line_buffer #(.IMG_W(IMG_W), .DATA_W(PIX_W)) u_lb0 (
    .clk(clk), .rst(rst), .en(shift), .din(pix_in), .dout(lb0_dout)
  );
  nms_line_buffer #(.IMG_W(IMG_W), .DATA_W(PIX_W)) u_lb1 (
    .clk(clk), .rst(rst), .en(shift), .din(lb0_dout), .dout(lb1_dout)
  );

  // The 3x3 window is the two registered columns plus the incoming column,
  // which lets the result for q be registered in the same cycle p arrives.
  always_comb begin
    for (int r = 0; r < 3; r++) w_d[r][0] = w_q[r][1];
    w_d[0][1] = lb1_dout;
    w_d[1][1] = lb0_dout;
    w_d[2][1] = pix_in;
  end

  always_ff @(posedge clk) begin
    if (shift) w_q <= w_d;
  end

  // Stage 1: direction-selected compare of the centre against its two neighbours.
  assign c_mag = w_q[1][1][MAG_W-1:0];
  assign c_ang = w_q[1][1][MAG_W+1:MAG_W];

  always_comb begin
    early = w_q[1][0][MAG_W-1:0];       // W
    late  = lb0_dout[MAG_W-1:0];        // E
    case (c_ang)
      ANG_D45: begin
        early = lb1_dout[MAG_W-1:0];    // NE
        late  = w_q[2][0][MAG_W-1:0];   // SW
      end
      ANG_V: begin
        early = w_q[0][1][MAG_W-1:0];   // N
        late  = w_q[2][1][MAG_W-1:0];   // S
      end
      ANG_D135: begin
        early = w_q[0][0][MAG_W-1:0];   // NW
        late  = pix_in[MAG_W-1:0];      // SE
      end
      default: ;
    endcase
  end

  assign interior = (qrow_q != '0) && (qrow_q != LAST_ROW) &&
                    (qcol_q != '0) && (qcol_q != LAST_COL);

  always_comb begin
    state_d = state_q;
    pcol_d  = pcol_q;
    prow_d  = prow_q;
    qcol_d  = qcol_q;
    qrow_d  = qrow_q;
    flush_d = flush_q;
    if (take) begin
      state_d = RUN;
      if (cur_col == LAST_COL) begin
        pcol_d = '0;
        prow_d = cur_row + 1'b1;
      end else begin
        pcol_d = cur_col + 1'b1;
        prow_d = cur_row;
      end
      if (cur_col == LAST_COL && cur_row == LAST_ROW) begin
        state_d = FLUSH;
        flush_d = FL_W'(IMG_W);       // counts IMG_W..0, i.e. IMG_W+1 cycles
      end
    end
    // A start (also an abort) restarts the output raster at (0,0).
    if (start) begin
      qcol_d = '0;
      qrow_d = '0;
    end
    if (flushing) begin
      if (flush_q == '0) state_d = IDLE;
      else               flush_d = flush_q - 1'b1;
    end
    if (emit) begin
      if (qcol_q == LAST_COL) begin
        qcol_d = '0;
        qrow_d = (qrow_q == LAST_ROW) ? '0 : qrow_q + 1'b1;
      end else begin
        qcol_d = qcol_q + 1'b1;
      end
    end
    in_ready_d  = (state_d != FLUSH);
    out_valid_d = emit;
    out_sof_d   = emit && qcol_q == '0 && qrow_q == '0;
    out_eof_d   = emit && qcol_q == LAST_COL && qrow_q == LAST_ROW;
    out_mag_d   = (emit && interior && keep_fn(c_mag, early, late)) ? c_mag : '0;
  end

  // Stage 2: registered control and output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pcol_q      <= '0;
      prow_q      <= '0;
      qcol_q      <= '0;
      qrow_q      <= '0;
      flush_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      out_mag_q   <= '0;
    end else begin
      state_q     <= state_d;
      pcol_q      <= pcol_d;
      prow_q      <= prow_d;
      qcol_q      <= qcol_d;
      qrow_q      <= qrow_d;
      flush_q     <= flush_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
      out_mag_q   <= out_mag_d;
    end
  end

  assign s.in_ready  = in_ready_q;
  assign s.out_valid = out_valid_q;
  assign s.out_sof   = out_sof_q;
  assign s.out_eof   = out_eof_q;
  assign s.out_mag   = out_mag_q;
endmodule

// File: tb/tb_nms_stream.sv
// Scoreboard bench for nms_stream with a 5x4 frame and 11-bit magnitudes.
module tb_nms_stream;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int MW = 11;

  typedef struct packed {
    logic          sof;
    logic          eof;
    logic [MW-1:0] mag;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nms_stream_if #(.MAG_W(MW)) bus ();

  nms_stream #(.IMG_W(W), .IMG_H(H), .MAG_W(MW)) dut (
    .clk(clk),
    .rst(rst),
    .s  (bus)
  );

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  obs_t exp_q[$];
  obs_t got_q[$];
  int   got_cyc[$];
  logic [MW-1:0] fm [N];
  logic [1:0]    fa [N];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.out_valid) begin
      got_q.push_back({bus.out_sof, bus.out_eof, bus.out_mag});
      got_cyc.push_back(cyc);
    end
  end

  function automatic logic [MW-1:0] px(int r, int c);
    return fm[r*W + c];
  endfunction

  // Independent 2-D reference of the suppression rule.
  function automatic logic [MW-1:0] ref_mag(int r, int c);
    logic [MW-1:0] ctr, e, l;
    if (r == 0 || r == H-1 || c == 0 || c == W-1) return '0;
    ctr = px(r, c);
    case (fa[r*W + c])
      2'd0:    begin e = px(r, c-1);   l = px(r, c+1);   end
      2'd1:    begin e = px(r-1, c+1); l = px(r+1, c-1); end
      2'd2:    begin e = px(r-1, c);   l = px(r+1, c);   end
      default: begin e = px(r-1, c-1); l = px(r+1, c+1); end
    endcase
    return (ctr > e && ctr >= l) ? ctr : '0;
  endfunction

  task automatic clear_queues();
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic push_expected();
    for (int q = 0; q < N; q++)
      exp_q.push_back({(q == 0), (q == N-1), ref_mag(q / W, q % W)});
  endtask

  // Called at a negedge; presents a pixel, returns at the negedge after transfer.
  task automatic send_pixel(input logic [MW-1:0] m, input logic [1:0] a, input logic sof);
    int t = 0;
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout in_ready=%0b required 1", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_sof   = sof;
    bus.in_mag   = m;
    bus.in_angle = a;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic drive_frame();
    push_expected();
    for (int p = 0; p < N; p++) send_pixel(fm[p], fa[p], (p == 0));
  endtask

  task automatic wait_outputs(input int n);
    int t = 0;
    while (got_q.size() < n && t < 400) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sof = 1'b0;
    bus.in_mag = '0;
    bus.in_angle = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_sof, bus.out_eof, bus.out_mag} !== {4'b1000, 11'd0}) begin
      n_fail++;
      $display("FAIL reset_init rdy=%0b vld=%0b mag=%0d required rdy=1 vld=0 mag=0",
               bus.in_ready, bus.out_valid, bus.out_mag);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int p = 0; p < 8; p++) send_pixel(11'(p + 1), 2'd0, (p == 0));
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_prefire out_valid=%0b required 1", bus.out_valid);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_sof, bus.out_eof, bus.out_mag} !== {4'b1000, 11'd0}) begin
      n_fail++;
      $display("FAIL reset_async rdy=%0b vld=%0b mag=%0d required rdy=1 vld=0 mag=0",
               bus.in_ready, bus.out_valid, bus.out_mag);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_queues();
    for (int p = 0; p < 10; p++) send_pixel(11'(50 + p), 2'd2, 1'b0);
    repeat (10) @(negedge clk);
    n_checks++;
    if (got_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_nosof outputs=%0d required 0", got_q.size());
    end
    clear_queues();
  endtask

  task automatic test_flat();
    int x6, lowc, idx;
    clear_queues();
    for (int p = 0; p < N; p++) begin
      fm[p] = 11'd10;
      fa[p] = 2'd0;
    end
    push_expected();
    x6 = -1;
    for (int p = 0; p < N; p++) begin
      send_pixel(fm[p], fa[p], (p == 0));
      if (p == 6) x6 = cyc;
    end
    lowc = 0;
    while (!bus.in_ready && lowc < 20) begin
      lowc++;
      @(negedge clk);
    end
    n_checks++;
    if (lowc != W + 1) begin
      n_fail++;
      $display("FAIL flat_flush_len got %0d required %0d", lowc, W + 1);
    end
    wait_outputs(N);
    n_checks++;
    if (got_cyc.size() == 0 || got_cyc[0] != x6) begin
      n_fail++;
      $display("FAIL flat_first_latency got cyc %0d required %0d",
               (got_cyc.size() == 0) ? -1 : got_cyc[0], x6);
    end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL flat_count got %0d required %0d", got_q.size(), exp_q.size());
    end
    idx = 0;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      obs_t g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL flat_out[%0d] got sof=%0b eof=%0b mag=%0d required sof=%0b eof=%0b mag=%0d",
                 idx, g.sof, g.eof, g.mag, e.sof, e.eof, e.mag);
      end
      idx++;
    end
    clear_queues();
  endtask

  task automatic test_peak();
    int idx;
    clear_queues();
    for (int p = 0; p < N; p++) begin
      fm[p] = 11'd50;
      fa[p] = 2'd2;
    end
    fm[1*W + 2] = 11'd100;
    drive_frame();
    wait_outputs(N);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL peak_count got %0d required %0d", got_q.size(), exp_q.size());
    end
    idx = 0;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      obs_t g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL peak_out[%0d] got sof=%0b eof=%0b mag=%0d required sof=%0b eof=%0b mag=%0d",
                 idx, g.sof, g.eof, g.mag, e.sof, e.eof, e.mag);
      end
      idx++;
    end
    clear_queues();
  endtask

  task automatic test_tie();
    int idx;
    clear_queues();
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < N; p++) begin
        fm[p] = '0;
        fa[p] = 2'd0;
      end
      fm[2*W + 2] = 11'd80;
      fm[2*W + 1] = (k == 0) ? 11'd80 : 11'd0;
      fm[2*W + 3] = (k == 0) ? 11'd0  : 11'd80;
      drive_frame();
    end
    wait_outputs(2 * N);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL tie_count got %0d required %0d", got_q.size(), exp_q.size());
    end
    idx = 0;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      obs_t g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL tie_out[%0d] got sof=%0b eof=%0b mag=%0d required sof=%0b eof=%0b mag=%0d",
                 idx, g.sof, g.eof, g.mag, e.sof, e.eof, e.mag);
      end
      idx++;
    end
    clear_queues();
  endtask

  task automatic test_diagonal();
    int idx, ei, li;
    clear_queues();
    for (int k = 0; k < 4; k++) begin
      for (int p = 0; p < N; p++) begin
        fm[p] = '0;
        fa[p] = 2'd0;
      end
      fm[1*W + 1] = 11'd90;
      fa[1*W + 1] = (k < 2) ? 2'd1 : 2'd3;
      ei = (k < 2) ? (0*W + 2) : (0*W + 0);
      li = (k < 2) ? (2*W + 0) : (2*W + 2);
      fm[ei] = (k % 2 == 0) ? 11'd90 : 11'd10;
      fm[li] = (k % 2 == 0) ? 11'd10 : 11'd90;
      drive_frame();
    end
    wait_outputs(4 * N);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL diag_count got %0d required %0d", got_q.size(), exp_q.size());
    end
    idx = 0;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      obs_t g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL diag_out[%0d] got sof=%0b eof=%0b mag=%0d required sof=%0b eof=%0b mag=%0d",
                 idx, g.sof, g.eof, g.mag, e.sof, e.eof, e.mag);
      end
      idx++;
    end
    clear_queues();
  endtask

  task automatic test_abort();
    int idx;
    clear_queues();
    // Aborted frame: p=6,7 emit row-0 border pixels q=0,1, never an eof.
    exp_q.push_back({1'b1, 1'b0, 11'd0});
    exp_q.push_back({1'b0, 1'b0, 11'd0});
    for (int p = 0; p < 8; p++)
      send_pixel(11'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), (p == 0));
    for (int p = 0; p < N; p++) begin
      fm[p] = 11'($urandom_range(0, 255));
      fa[p] = 2'($urandom_range(0, 3));
    end
    drive_frame();
    wait_outputs(N + 2);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL abort_count got %0d required %0d", got_q.size(), exp_q.size());
    end
    idx = 0;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      obs_t g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL abort_out[%0d] got sof=%0b eof=%0b mag=%0d required sof=%0b eof=%0b mag=%0d",
                 idx, g.sof, g.eof, g.mag, e.sof, e.eof, e.mag);
      end
      idx++;
    end
    clear_queues();
  endtask

  initial begin
    test_reset();
    test_flat();
    test_peak();
    test_tie();
    test_diagonal();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete, time=%0t", $time);
    $fatal(1);
  end
endmodule
